shadowmask_loader: RTL and testbench

- Sequences a built-in shadow-mask preset into the shadow mask stage's config write port (mask_wr/mask_data) on clk_sys.
- Sits directly upstream of the shadow mask block's config interface, driven by the core's video-settings logic (preset select + load strobe).
- Emits the full command stream for the selected preset: index reset, vmax, hmax, then every LUT entry in raster order.
- Optionally auto-loads after reset so the mask is valid before first frame.

---
 rtl/shadowmask_loader.sv | 185 ++++++++++++++++++
 tb/tb_shadowmask_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadowmask_loader.sv
// Streams a built-in shadow-mask preset (index reset, vmax, hmax, LUT entries)
// into the shadow mask stage's config write port, with optional spacing between writes.
module shadowmask_loader #(
   parameter int WR_GAP    = 0,
   parameter bit AUTO_LOAD = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [1:0]  preset_sel,
   input  logic        load_req,
   output logic        busy,
   output logic        done,
   output logic        mask_wr,
   output logic [15:0] mask_data
);

   localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_IDX, S_VMAX, S_HMAX, S_LUT, S_GAP, S_DONE
   } state_t;

   state_t          state_reg, state_next;
   state_t          ret_reg, ret_next;
   logic [GW-1:0]   gap_reg, gap_next;
   logic [7:0]      idx_reg, idx_next;
   logic [1:0]      sel_reg, sel_next;
   logic            pending_reg, pending_next;
   logic            auto_reg;
   logic [15:0]     hold_reg;

   logic [3:0]      vmax, hmax;
   logic [10:0]     lut;
   logic [8:0]      vp1, hp1;
   logic [17:0]     prod;
   logic [7:0]      last_idx;
   logic            in_write;
   logic            is_busy;
   logic            req;
   state_t          follow;
   logic [15:0]     cur_word;

   // Preset ROM, addressed by the latched preset and the LUT index counter
   always_comb begin
      vmax = 4'd0;
      hmax = 4'd0;
      lut  = 11'h000;
      case (sel_reg)
         2'd0: begin
            vmax = 4'd1;
            hmax = 4'd1;
            case (idx_reg[1:0])
               2'd0:    lut = 11'h70F;
               2'd1:    lut = 11'h00C;
               2'd2:    lut = 11'h00C;
               default: lut = 11'h70F;
            endcase
         end
         2'd1: begin
            vmax = 4'd0;
            hmax = 4'd2;
            case (idx_reg[1:0])
               2'd0:    lut = 11'h408;
               2'd1:    lut = 11'h208;
               default: lut = 11'h108;
            endcase
         end
         2'd2: begin
            vmax = 4'd1;
            hmax = 4'd1;
            case (idx_reg[1:0])
               2'd0:    lut = 11'h700;
               2'd1:    lut = 11'h00C;
               2'd2:    lut = 11'h00C;
               default: lut = 11'h700;
            endcase
         end
         default: begin
            vmax = 4'd0;
            hmax = 4'd0;
            lut  = 11'h700;
         end
      endcase
   end

   assign vp1      = {5'd0, vmax} + 9'd1;
   assign hp1      = {5'd0, hmax} + 9'd1;
   assign prod     = {9'd0, vp1} * {9'd0, hp1};
   assign last_idx = 8'(prod - 18'd1);

   assign in_write = (state_reg == S_IDX) || (state_reg == S_VMAX) ||
                     (state_reg == S_HMAX) || (state_reg == S_LUT);
   assign is_busy  = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign req      = load_req | auto_reg;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         ret_reg     <= S_IDLE;
         gap_reg     <= '0;
         idx_reg     <= 8'd0;
         sel_reg     <= 2'd0;
         pending_reg <= 1'b0;
         auto_reg    <= AUTO_LOAD;
         hold_reg    <= 16'h0000;
      end else begin
         state_reg   <= state_next;
         ret_reg     <= ret_next;
         gap_reg     <= gap_next;
         idx_reg     <= idx_next;
         sel_reg     <= sel_next;
         pending_reg <= pending_next;
         auto_reg    <= 1'b0;
         if (in_write)
            hold_reg <= cur_word;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ret_next     = ret_reg;
      gap_next     = gap_reg;
      idx_next     = idx_reg;
      sel_next     = sel_reg;
      pending_next = pending_reg;
      follow       = S_IDLE;
      case (state_reg)
         S_IDLE: begin
            if (req) begin
               state_next = S_IDX;
               sel_next   = preset_sel;
            end
         end
         S_IDX:  follow = S_VMAX;
         S_VMAX: follow = S_HMAX;
         S_HMAX: begin
            follow   = S_LUT;
            idx_next = 8'd0;
         end
         S_LUT: begin
            follow   = (idx_reg == last_idx) ? S_DONE : S_LUT;
            idx_next = idx_reg + 8'd1;
         end
         S_GAP: begin
            if (gap_reg == '0)
               state_next = ret_reg;
            else
               gap_next = gap_reg - 1'b1;
         end
         S_DONE: begin
            // A queued request restarts immediately, skipping the IDLE dwell
            if (pending_reg) begin
               state_next   = S_IDX;
               sel_next     = preset_sel;
               pending_next = 1'b0;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (in_write) begin
         ret_next   = follow;
         gap_next   = GW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
         state_next = (WR_GAP == 0) ? follow : S_GAP;
      end
      if (is_busy && load_req)
         pending_next = 1'b1;
   end

   always_comb begin
      case (state_reg)
         S_IDX:   cur_word = 16'h0000;
         S_VMAX:  cur_word = {12'h200, vmax};
         S_HMAX:  cur_word = {12'h400, hmax};
         S_LUT:   cur_word = {5'b01100, lut};
         default: cur_word = hold_reg;
      endcase
      busy      = is_busy;
      done      = (state_reg == S_DONE);
      mask_wr   = in_write;
      mask_data = cur_word;
   end

endmodule

// File: tb/tb_shadowmask_loader.sv
// Randomized scoreboard bench: predicted command words/done times are queued by the
// stimulus and checked by a monitor that also decodes the stream like the mask stage.
module tb_shadowmask_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst0, rst1, req0, req1;
   logic [1:0]  sel0, sel1;
   logic        busy0, busy1, done0, done1, wr0, wr1;
   logic [15:0] data0, data1;

   shadowmask_loader #(.WR_GAP(0), .AUTO_LOAD(1'b0)) u_dut0 (
      .clk_sys(clk), .reset(rst0), .preset_sel(sel0), .load_req(req0),
      .busy(busy0), .done(done0), .mask_wr(wr0), .mask_data(data0));

   shadowmask_loader #(.WR_GAP(1), .AUTO_LOAD(1'b1)) u_dut1 (
      .clk_sys(clk), .reset(rst1), .preset_sel(sel1), .load_req(req1),
      .busy(busy1), .done(done1), .mask_wr(wr1), .mask_data(data1));

   int act = 0;
   logic        mw, dn, bz;
   logic [15:0] md;
   assign mw = (act == 1) ? wr1   : wr0;
   assign dn = (act == 1) ? done1 : done0;
   assign bz = (act == 1) ? busy1 : busy0;
   assign md = (act == 1) ? data1 : data0;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   exp_t word_q[$];
   int   done_q[$];
   int   preset_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   int          vmax_t [4] = '{1, 0, 1, 0};
   int          hmax_t [4] = '{1, 2, 1, 0};
   logic [10:0] lut_t [4][4] = '{'{11'h70F, 11'h00C, 11'h00C, 11'h70F},
                                 '{11'h408, 11'h208, 11'h108, 11'h000},
                                 '{11'h700, 11'h00C, 11'h00C, 11'h700},
                                 '{11'h700, 11'h000, 11'h000, 11'h000}};

   // Load starting at cycle s: word k appears at s+1+k*(gap+1), done right after the last gap
   task automatic push_load(input int s, input int p, output int d);
      int g, n;
      exp_t e;
      g = (act == 1) ? 1 : 0;
      n = (vmax_t[p] + 1) * (hmax_t[p] + 1);
      for (int k = 0; k < n + 3; k++) begin
         e.cyc = s + 1 + k * (g + 1);
         if (k == 0)      e.data = 16'h0000;
         else if (k == 1) e.data = 16'h2000 | 16'(vmax_t[p]);
         else if (k == 2) e.data = 16'h4000 | 16'(hmax_t[p]);
         else             e.data = 16'h6000 | {5'd0, lut_t[p][k-3]};
         word_q.push_back(e);
      end
      d = s + 1 + (n + 3) * (g + 1);
      done_q.push_back(d);
      preset_q.push_back(p);
   endtask

   // Model of the shadow mask config decoder
   int          dec_vmax, dec_hmax, dec_ptr;
   logic [10:0] dec_lut [256];
   logic [15:0] last_data = 16'h0000;
   exp_t        me;
   int          mp, mn, md_cyc;

   always @(negedge clk) begin
      if (mw) begin
         n_cmp++;
         if (word_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: cyc=%0d got data=%h, required no write", cyc, md);
         end else begin
            me = word_q.pop_front();
            if (me.cyc != cyc || me.data != md || !bz) begin
               n_fail++;
               $display("FAIL write: got cyc=%0d data=%h busy=%0b, required cyc=%0d data=%h busy=1",
                        cyc, md, bz, me.cyc, me.data);
            end
         end
         last_data = md;
         case (md[15:13])
            3'b000: dec_ptr = 0;
            3'b001: dec_vmax = int'(md[3:0]);
            3'b010: dec_hmax = int'(md[3:0]);
            3'b011: begin
               dec_lut[dec_ptr[7:0]] = md[10:0];
               dec_ptr++;
            end
            default: ;
         endcase
         $display("cyc=%0d act=%0d write %h", cyc, act, md);
      end else if (bz) begin
         n_cmp++;
         if (md != last_data) begin
            n_fail++;
            $display("FAIL gap_hold: cyc=%0d got data=%h, required %h", cyc, md, last_data);
         end
      end
      if (dn) begin
         n_cmp++;
         if (done_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: cyc=%0d got done=1, required 0", cyc);
         end else begin
            md_cyc = done_q.pop_front();
            if (md_cyc != cyc || bz) begin
               n_fail++;
               $display("FAIL done: got cyc=%0d busy=%0b, required cyc=%0d busy=0", cyc, bz, md_cyc);
            end
         end
         if (preset_q.size() != 0) begin
            mp = preset_q.pop_front();
            mn = (vmax_t[mp] + 1) * (hmax_t[mp] + 1);
            n_cmp++;
            if (dec_vmax != vmax_t[mp] || dec_hmax != hmax_t[mp] || dec_ptr != mn) begin
               n_fail++;
               $display("FAIL decoded_geom p%0d: got vmax=%0d hmax=%0d n=%0d, required %0d %0d %0d",
                        mp, dec_vmax, dec_hmax, dec_ptr, vmax_t[mp], hmax_t[mp], mn);
            end
            for (int i = 0; i < mn; i++) begin
               n_cmp++;
               if (dec_lut[i] != lut_t[mp][i]) begin
                  n_fail++;
                  $display("FAIL decoded_lut p%0d[%0d]: got %h, required %h",
                           mp, i, dec_lut[i], lut_t[mp][i]);
               end
            end
         end
         $display("cyc=%0d act=%0d done", cyc, act);
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic set_req(input logic v);
      if (act == 1) req1 = v; else req0 = v;
   endtask

   task automatic set_sel(input int v);
      if (act == 1) sel1 = 2'(v); else sel0 = 2'(v);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_idle;
      int k = 0;
      while ((done_q.size() != 0 || word_q.size() != 0) && k < 300) begin
         tick();
         k++;
      end
      if (k >= 300) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: %0d words / %0d done still outstanding, required 0",
                  word_q.size(), done_q.size());
         word_q.delete();
         done_q.delete();
         preset_q.delete();
      end
      tick();
   endtask

   task automatic do_load(input int p, output int s, output int d);
      set_sel(p);
      set_req(1'b1);
      s = cyc;
      push_load(s, p, d);
      tick();
      set_req(1'b0);
   endtask

   task automatic random_loads(input int count);
      int s, d, d2, k, p2;
      for (int it = 0; it < count; it++) begin
         do_load(int'($urandom_range(3, 0)), s, d);
         if ($urandom_range(1, 0) == 1) begin
            k = int'($urandom_range(d - 1, s + 1));
            wait_cyc(k);
            set_sel(int'($urandom_range(3, 0)));
            set_req(1'b1);
            p2 = int'($urandom_range(3, 0));
            push_load(d, p2, d2);
            tick();
            set_req(1'b0);
            set_sel(int'($urandom_range(3, 0)));
            wait_cyc(d);
            set_sel(p2);
         end
         wait_idle();
         repeat ($urandom_range(3, 0)) tick();
      end
   endtask

   initial begin
      int s, d, d2;
      rst0 = 1'b1; rst1 = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      sel0 = 2'd0; sel1 = 2'd0;
      repeat (3) tick();

      n_cmp++;
      if ({busy0, done0, wr0, data0} != 19'd0) begin
         n_fail++;
         $display("FAIL reset0: got busy=%0b done=%0b wr=%0b data=%h, required all 0",
                  busy0, done0, wr0, data0);
      end
      n_cmp++;
      if ({busy1, done1, wr1, data1} != 19'd0) begin
         n_fail++;
         $display("FAIL reset1: got busy=%0b done=%0b wr=%0b data=%h, required all 0",
                  busy1, done1, wr1, data1);
      end

      rst0 = 1'b0;
      repeat (2) tick();

      // Back-to-back preset 0
      do_load(0, s, d);
      wait_idle();

      // Pending request at the 2nd LUT write; preset_sel moves to 2 before DONE
      do_load(0, s, d);
      wait_cyc(s + 5);
      set_sel(1);
      set_req(1'b1);
      push_load(d, 2, d2);
      tick();
      set_req(1'b0);
      set_sel(2);
      wait_idle();

      // Reset during the HMAX write, with load_req also high: reset wins
      do_load(1, s, d);
      wait_cyc(s + 3);
      rst0 = 1'b1;
      req0 = 1'b1;
      tick();
      n_cmp++;
      if (busy0 || wr0 || done0 || data0 != 16'h0000) begin
         n_fail++;
         $display("FAIL reset_midload: got busy=%0b wr=%0b done=%0b data=%h, required 0 0 0 0000",
                  busy0, wr0, done0, data0);
      end
      for (int i = word_q.size() - 1; i >= 0; i--)
         if (word_q[i].cyc >= s + 4) word_q.delete(i);
      void'(done_q.pop_back());
      void'(preset_q.pop_back());
      rst0 = 1'b0;
      req0 = 1'b0;
      repeat (5) tick();
      do_load(3, s, d);
      wait_idle();

      random_loads(8);

      // Second instance: WR_GAP=1, AUTO_LOAD=1
      act = 1;
      sel1 = 2'd3;
      tick();
      rst1 = 1'b0;
      s = cyc;
      push_load(s, 3, d);
      wait_idle();

      do_load(1, s, d);
      wait_idle();

      random_loads(8);

      n_cmp++;
      if (word_q.size() != 0 || done_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: got %0d words / %0d done pending, required 0",
                  word_q.size(), done_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
